// File: rtl/i2c_pkg.sv
// Shared constants for the single-byte I2C master: state encoding, slot counts
// and the default SCL half-period.
package i2c_pkg;
  localparam int SCL_HALF_DEF = 62;
  localparam int BITS_ADDR    = 8;
  localparam int BITS_DATA    = 8;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] ADDR   = 4'd2;
  localparam logic [3:0] A_ACK  = 4'd3;
  localparam logic [3:0] WDATA  = 4'd4;
  localparam logic [3:0] W_ACK  = 4'd5;
  localparam logic [3:0] RDATA  = 4'd6;
  localparam logic [3:0] R_NACK = 4'd7;
  localparam logic [3:0] STOP   = 4'd8;
endpackage

// File: rtl/i2c_tick_gen.sv
// SCL half-period timebase: counts 0..SCL_HALF-1 while enabled, flags the
// wrap cycle (tick) and the first cycle of each half (first).
module i2c_tick_gen #(
  parameter int SCL_HALF = 62,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic first
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCL_HALF - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en) begin
      if (cnt == LAST)   cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

  assign tick  = en && (cnt == LAST);
  assign first = en && (cnt == '0);
endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte with ACK/NACK, STOP.
// Every state is made of half-periods; SDA only moves one cycle into a low half.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int SCL_HALF = SCL_HALF_DEF,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       SCL,
  output logic       oSDA_en,
  input  logic       iSDA
);
  logic [3:0] state;
  logic       half;     // 0: first half of the step, 1: second half
  logic [2:0] bitcnt;
  logic [7:0] sh;
  logic [7:0] wd_l;
  logic       rw_l;
  logic       tick, first;

  i2c_tick_gen #(.SCL_HALF(SCL_HALF), .CNT_W(CNT_W)) u_tick (
    .CLK(CLK), .Reset(Reset), .en(busy), .clr(!busy), .tick(tick), .first(first)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;  half <= 1'b0;  bitcnt <= '0;  sh <= '0;  wd_l <= '0;  rw_l <= 1'b0;
      busy <= 1'b0;   done <= 1'b0;  ack_err <= 1'b0;  rdata <= '0;
      SCL <= 1'b1;    oSDA_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // the done cycle still reads as idle; hold off so the host sees busy=0 first
          if (start && !done) begin
            busy <= 1'b1;  state <= START;  half <= 1'b0;  bitcnt <= '0;
            oSDA_en <= 1'b1;  ack_err <= 1'b0;  rdata <= '0;
            sh <= {addr, rw};  rw_l <= rw;  wd_l <= wdata;
          end
        end
        START: begin
          if (tick) begin
            if (!half) begin half <= 1'b1; SCL <= 1'b0; end
            else begin half <= 1'b0; state <= ADDR; end
          end
        end
        STOP: begin
          if (first && !half) oSDA_en <= 1'b1;
          if (tick) begin
            if (!half) begin half <= 1'b1; SCL <= 1'b1; end
            else begin
              half <= 1'b0;  state <= IDLE;  busy <= 1'b0;  done <= 1'b1;  oSDA_en <= 1'b0;
            end
          end
        end
        default: begin
          // bit slot: low half drives/releases SDA, high half ends with iSDA sampled
          if (first && !half) oSDA_en <= ((state == ADDR) || (state == WDATA)) && !sh[7];
          if (tick && !half) begin
            half <= 1'b1;  SCL <= 1'b1;
          end else if (tick) begin
            half <= 1'b0;  SCL <= 1'b0;  bitcnt <= bitcnt + 3'd1;  sh <= {sh[6:0], 1'b0};
            case (state)
              ADDR:  if (bitcnt == 3'(BITS_ADDR - 1)) state <= A_ACK;
              A_ACK: begin
                bitcnt <= '0;
                if (iSDA)      begin ack_err <= 1'b1; state <= STOP; end
                else if (rw_l) state <= RDATA;
                else begin     state <= WDATA; sh <= wd_l; end
              end
              WDATA: if (bitcnt == 3'(BITS_DATA - 1)) state <= W_ACK;
              W_ACK: begin ack_err <= iSDA; state <= STOP; end
              RDATA: begin
                rdata <= {rdata[6:0], iSDA};
                if (bitcnt == 3'(BITS_DATA - 1)) state <= R_NACK;
              end
              default: state <= STOP;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a slot-level slave model drives iSDA, bus monitors
// record bits at SCL rise and START/STOP conditions, results checked per transaction.
module tb_i2c_master_ctrl;
  localparam int H = 8;

  logic       CLK = 1'b0, Reset = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, ack_err, SCL, oSDA_en, iSDA;
  logic [7:0] rdata;
  logic       slv = 1'b1;

  int   ntests = 0, nfail = 0;
  logic cap[$];
  int   base = 0;
  int   nstart = 0, nstop = 0, nviol = 0;
  logic slot_bits [0:19];
  logic pscl = 1'b1, psda = 1'b0;

  assign iSDA = ~oSDA_en & slv;

  i2c_master_ctrl #(.SCL_HALF(H), .CNT_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .SCL(SCL), .oSDA_en(oSDA_en), .iSDA(iSDA)
  );

  always #5 CLK = ~CLK;

  always @(posedge SCL) if (Reset) cap.push_back(iSDA);

  // slave presents the bit of slot n when SCL falls after n rises
  always @(negedge SCL) begin
    int n;
    n = cap.size() - base;
    slv = (n >= 0 && n < 20) ? slot_bits[n] : 1'b1;
  end

  always @(negedge iSDA) if (Reset && SCL) nstart++;
  always @(posedge iSDA) if (Reset && SCL) nstop++;

  always @(negedge CLK) begin
    if (Reset && SCL !== pscl && oSDA_en !== psda) nviol++;
    pscl = SCL;
    psda = oSDA_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] grab(input int i);
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++)
      v = {v[6:0], (base + i + k < cap.size()) ? cap[base + i + k] : 1'bx};
    return v;
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic aack, input logic wack, input logic [7:0] rd,
                         input bit hold, input bit poke, input int abort_at);
    int lat, s0, p0, v0, exp_lat, extra;
    bit got_done;
    for (int i = 0; i < 20; i++) slot_bits[i] = 1'b1;
    slot_bits[8] = aack;
    if (!aack) begin
      if (r) for (int i = 0; i < 8; i++) slot_bits[9 + i] = rd[7 - i];
      else   slot_bits[17] = wack;
    end
    @(negedge CLK);
    chk("idle_before_accept", busy, 0);
    base = cap.size();  s0 = nstart;  p0 = nstop;  v0 = nviol;
    start = 1'b1;  rw = r;  addr = a;  wdata = wd;
    @(posedge CLK);
    lat = 0;  got_done = 0;
    exp_lat = (aack ? 22 : 40) * H + 1;
    while (!got_done && lat < exp_lat + 20) begin
      @(negedge CLK);
      lat++;
      if (!hold) start = 1'b0;
      if (lat == 1) chk("busy_after_accept", busy, 1);
      if (poke && lat == 6 * H) begin
        start = 1'b1;  addr = ~a;  rw = ~r;  wdata = ~wd;
      end
      if (lat == abort_at) begin
        #2 Reset = 1'b0;
        #1;
        chk("rst_scl", SCL, 1);
        chk("rst_sda_en", oSDA_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        @(negedge CLK) Reset = 1'b1;
        return;
      end
      got_done = done;
    end
    chk("latency", lat, exp_lat);
    chk("ack_err", ack_err, aack ? 1 : (r ? 0 : wack));
    chk("rdata", rdata, (r && !aack) ? rd : 8'h00);
    chk("scl_rises", cap.size() - base, aack ? 10 : 19);
    chk("addr_bits", grab(0), {a, r});
    if (!aack) chk("data_bits", grab(9), r ? rd : wd);
    if (r && !aack) chk("rnack_released", cap[base + 17], 1);
    chk("start_cond", nstart - s0, 1);
    chk("stop_cond", nstop - p0, 1);
    chk("scl_sda_same_cycle", nviol - v0, 0);
    if (!hold) begin
      extra = 0;
      repeat (3) begin
        @(negedge CLK);
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    #12;
    chk("reset_scl", SCL, 1);
    chk("reset_sda_en", oSDA_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ack_err", ack_err, 0);
    chk("reset_rdata", rdata, 0);
    @(negedge CLK) Reset = 1'b1;

    run_txn(7'h2A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 0, 0);
    run_txn(7'h55, 1'b0, 8'h12, 1'b1, 1'b1, 8'h00, 0, 0, 0);
    run_txn(7'h10, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 0, 0, 0);
    run_txn(7'h33, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, 0, 1, 0);
    run_txn(7'h21, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 0, 25 * H + 3);
    run_txn(7'h21, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 0, 0);
    run_txn(7'h4B, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h00, 1, 0, 0);
    run_txn(7'h0E, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96, 1, 0, 0);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("hold_released_idle", busy, 0);

    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      logic [7:0] wd, rd;
      logic r, aack, wack;
      a    = 7'($urandom);
      wd   = 8'($urandom);
      rd   = 8'($urandom);
      r    = 1'($urandom);
      aack = ($urandom_range(0, 3) == 0);
      wack = 1'($urandom);
      run_txn(a, r, wd, aack, wack, rd, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
